mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous program/data RAM between the instruction-fetch stage (IF) and the load/store stage (LS) of the CPU core.
- Sits between the core datapath and the RAM, and lets the core's top level keep a single memory instance.
- Issues one transaction per free cycle and tracks outstanding reads for a fixed memory latency.
- Returns read data to the requester that issued the read.
- LS has priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- AW, 8, address width.
- DW, 16, data width.
- MEM_LAT, 1, cycles from the issue cycle (mem_en=1) to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 3, consecutive LS grants while if_req is pending before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- pcrst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch issued this cycle (combinational).
- if_rvalid  out  1  fetch data valid on if_rdata.
- if_rdata  out  DW  fetch read data.
- ls_req  in  1  load/store request; held with ls_we, ls_addr and ls_wdata until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  DW  store data.
- ls_gnt  out  1  load/store issued this cycle (combinational).
- ls_rvalid  out  1  load data valid on ls_rdata.
- ls_rdata  out  DW  load read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid MEM_LAT cycles after issue.

Behaviour:
- Reset (pcrst=1 at a clk edge):
  - State goes to IDLE; lat_cnt=0; owner=none; ls_streak=0.
  - While pcrst=1, all outputs are forced to 0: gnt, rvalid, mem_en, mem_we.
  - An outstanding read is discarded; no rvalid is produced after reset.
- States:
  - IDLE: no read outstanding.
  - WAIT: read outstanding; lat_cnt counts 1..MEM_LAT.
- Free cycle: state==IDLE, or state==WAIT with lat_cnt==MEM_LAT (the return cycle). Issue is permitted only in a free cycle.
- Arbitration in a free cycle:
  - Only one requester: it wins.
  - Both requesting and ls_streak<STARVE_MAX: LS wins.
  - Both requesting and ls_streak==STARVE_MAX: IF wins.
- ls_streak update:
  - LS grant with if_req=1: increment, saturating at STARVE_MAX.
  - IF grant: clear to 0.
  - LS grant with if_req=0: clear to 0.
- Issue cycle:
  - Assert the winner's gnt and mem_en=1.
  - Drive mem_addr from the winner.
  - mem_we = ls_we for an LS grant, 0 for an IF grant.
  - mem_wdata = ls_wdata.
  - mem_addr and mem_wdata are don't-care when mem_en=0; they are held at the last issued values.
- Store (LS, ls_we=1):
  - Completes in the issue cycle; no rvalid.
  - Next state is IDLE unless another issue occurs in the same cycle.
- Read (IF, or LS with ls_we=0):
  - Next state is WAIT; lat_cnt=1; owner=winner.
  - In the cycle lat_cnt==MEM_LAT, the owner's rvalid=1 and its rdata=mem_rdata (combinational pass-through).
  - The non-owner's rvalid stays 0.
- Back-to-back: a new issue in the return cycle is legal (pipelined RAM). The state reloads to WAIT with lat_cnt=1 if it is a read, or goes to IDLE if it is a store. For MEM_LAT=1 this sustains one access per cycle.
- if_rdata and ls_rdata are driven 0 when the corresponding rvalid=0.
- A requester deasserting req before gnt is legal: the request is withdrawn and no gnt is given.
- No X propagation is allowed: every output is defined after reset regardless of input state.

Test Plan:
- Reset mid-read: MEM_LAT=2; IF read at addr 0x10 is issued; pcrst=1 on the next cycle -> if_rvalid never asserts, mem_en=0 during reset, and IF is granted cleanly after release.
- Single fetch: MEM_LAT=1; if_req at addr 0x05 with RAM[0x05]=0xBEEF -> if_gnt and mem_en in cycle T, if_rvalid=1 and if_rdata=0xBEEF in cycle T+1, ls_rvalid=0.
- Contention: both request every cycle with ls_we=0, STARVE_MAX=3, MEM_LAT=1 -> grant order LS, LS, LS, IF, LS, LS, LS, IF, and each rvalid is routed to the correct owner.
- Store then load: LS store 0x1234 to 0x20, then LS load 0x20 in the next cycle -> mem_we=1 only in the store cycle, no rvalid for the store, ls_rdata=0x1234 one cycle after the load.
- Latency hold-off: MEM_LAT=3; LS load issued in cycle T while if_req is held -> no grant in T+1 and T+2, if_gnt in T+3 coinciding with ls_rvalid.
- Withdrawn request: if_req pulses for one cycle during WAIT -> no if_gnt, and ls_streak is unaffected by the withdrawn request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          pcrst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam logic [2:0] LAT  = 3'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t        state, state_nxt;
    owner_t        owner, owner_nxt;
    logic [2:0]    lat_cnt, lat_cnt_nxt;
    logic [3:0]    ls_streak, ls_streak_nxt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          ret_cycle;
    logic          free_cycle;
    logic          win_if;
    logic          win_ls;

    // State register; addr/wdata hold the last issued values while the RAM is idle
    always_ff @(posedge clk) begin
        if (pcrst) begin
            state     <= S_IDLE;
            owner     <= OWN_NONE;
            lat_cnt   <= 3'd0;
            ls_streak <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            lat_cnt   <= lat_cnt_nxt;
            ls_streak <= ls_streak_nxt;
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
        end
    end

    // Arbitration, next-state and all outputs; reset masks every grant and valid
    always_comb begin
        ret_cycle     = (state == S_WAIT) && (lat_cnt == LAT);
        free_cycle    = ((state == S_IDLE) || ret_cycle) && !pcrst;
        win_ls        = 1'b0;
        win_if        = 1'b0;
        state_nxt     = state;
        owner_nxt     = owner;
        lat_cnt_nxt   = lat_cnt;
        ls_streak_nxt = ls_streak;

        // LS wins unless the fetch side has been passed over STARVE_MAX times in a row
        if (free_cycle) begin
            if (ls_req && (!if_req || (ls_streak < SMAX))) begin
                win_ls = 1'b1;
            end else if (if_req) begin
                win_if = 1'b1;
            end
        end

        if (state == S_WAIT) begin
            if (ret_cycle) begin
                state_nxt   = S_IDLE;
                owner_nxt   = OWN_NONE;
                lat_cnt_nxt = 3'd0;
            end else begin
                lat_cnt_nxt = lat_cnt + 3'd1;
            end
        end

        // A new issue in the return cycle overrides the drop back to IDLE
        if (win_ls) begin
            if (if_req) begin
                ls_streak_nxt = (ls_streak == SMAX) ? ls_streak : ls_streak + 4'd1;
            end else begin
                ls_streak_nxt = 4'd0;
            end
            if (!ls_we) begin
                state_nxt   = S_WAIT;
                owner_nxt   = OWN_LS;
                lat_cnt_nxt = 3'd1;
            end
        end else if (win_if) begin
            ls_streak_nxt = 4'd0;
            state_nxt     = S_WAIT;
            owner_nxt     = OWN_IF;
            lat_cnt_nxt   = 3'd1;
        end

        if_gnt    = win_if;
        ls_gnt    = win_ls;
        mem_en    = win_if || win_ls;
        mem_we    = win_ls && ls_we;
        mem_addr  = win_ls ? ls_addr : (win_if ? if_addr : addr_q);
        mem_wdata = mem_en ? ls_wdata : wdata_q;

        if_rvalid = ret_cycle && (owner == OWN_IF) && !pcrst;
        ls_rvalid = ret_cycle && (owner == OWN_LS) && !pcrst;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = ls_rvalid ? mem_rdata : '0;
    end

endmodule
